// File: rtl/cache_port_checker.sv
// Drives a stream of load/store vectors into a cache port and checks load data
// against a byte-accurate reference memory, reporting the first error found.
module cache_port_checker #(
  parameter int WORD_NUM    = 1024,
  parameter int TEST_NUM    = 4096,
  parameter int OUTSTANDING = 4,
  parameter int TIMEOUT     = 1000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  output logic [31:0] vec_idx,
  input  logic [31:0] vec_addr,
  input  logic [4:0]  vec_mem_type,
  input  logic [31:0] vec_wdata,
  output logic        dut_valid,
  output logic [31:0] dut_addr,
  output logic [4:0]  dut_mem_type,
  output logic [31:0] dut_wdata,
  input  logic        dut_miss,
  input  logic        dut_commit,
  input  logic [31:0] dut_rdata,
  output logic        done,
  output logic        pass,
  output logic [1:0]  err_code,
  output logic [31:0] err_idx,
  output logic [31:0] err_expect,
  output logic [31:0] err_actual,
  output logic [2:0]  state_dbg
);

  localparam int AW = $clog2(WORD_NUM);
  localparam int PW = $clog2(OUTSTANDING);

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_IDLE = 3'd1,
    S_RUN  = 3'd2,
    S_PASS = 3'd3,
    S_FAIL = 3'd4
  } state_t;

  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] addr;
    logic [4:0]  mem_type;
    logic [31:0] wdata;
  } req_t;

  // Handshake: a request issues on any clk edge where dut_valid && !dut_miss;
  // the addr/type/wdata are held by the vector source until that edge, and
  // each dut_commit retires the oldest outstanding request in issue order.

  state_t        state;
  req_t          fifo_mem [OUTSTANDING];
  logic [31:0]   ref_mem  [WORD_NUM];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic [AW-1:0] init_cnt;
  logic [31:0]   wdog;
  logic [31:0]   commit_cnt;

  logic        fifo_full, fifo_empty, issue, commit_run, pop, load_bad;
  req_t        head;
  logic [AW-1:0] head_word_idx;
  logic [31:0] head_word, shifted, expected, store_word;
  logic [2:0]  sz;
  logic [1:0]  lane;

  assign dut_addr     = vec_addr;
  assign dut_mem_type = vec_mem_type;
  assign dut_wdata    = vec_wdata;
  assign state_dbg    = state;

  assign fifo_full  = (count == (PW+1)'(OUTSTANDING));
  assign fifo_empty = (count == '0);
  assign dut_valid  = (state == S_RUN) && !fifo_full && (vec_idx < 32'(TEST_NUM));
  assign issue      = dut_valid && !dut_miss;
  assign commit_run = (state == S_RUN) && dut_commit;
  assign pop        = commit_run && !fifo_empty;

  assign head          = fifo_mem[rd_ptr];
  assign head_word_idx = head.addr[AW+1:2];
  assign head_word     = ref_mem[head_word_idx];
  assign sz            = head.mem_type[2:0];
  assign lane          = head.addr[1:0];

  always_comb begin
    shifted  = head_word;
    expected = head_word;
    case (sz)
      3'b000: begin
        shifted  = head_word >> {lane, 3'b000};
        expected = {{24{shifted[7]}}, shifted[7:0]};
      end
      3'b100: begin
        shifted  = head_word >> {lane, 3'b000};
        expected = {24'h0, shifted[7:0]};
      end
      3'b001: begin
        shifted  = head_word >> {head.addr[1], 4'b0000};
        expected = {{16{shifted[15]}}, shifted[15:0]};
      end
      3'b101: begin
        shifted  = head_word >> {head.addr[1], 4'b0000};
        expected = {16'h0, shifted[15:0]};
      end
      default: expected = head_word;
    endcase
  end

  // Byte-merge for stores; the load compare above still sees the old word.
  always_comb begin
    store_word = head_word;
    case (sz[1:0])
      2'b00:   store_word[{lane, 3'b000} +: 8] = head.wdata[7:0];
      2'b01:   store_word[{head.addr[1], 4'b0000} +: 16] = head.wdata[15:0];
      default: store_word = head.wdata;
    endcase
  end

  assign load_bad = head.mem_type[3] && (dut_rdata != expected);

  always_ff @(posedge clk) begin
    if (state == S_INIT)
      ref_mem[init_cnt] <= {{(32-AW){1'b0}}, init_cnt};
    else if (pop && head.mem_type[4])
      ref_mem[head_word_idx] <= store_word;
  end

  always_ff @(posedge clk) begin
    if (issue)
      fifo_mem[wr_ptr] <= {vec_idx, vec_addr, vec_mem_type, vec_wdata};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_INIT;
      init_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      vec_idx    <= '0;
      wdog       <= '0;
      commit_cnt <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_code   <= 2'd0;
      err_idx    <= '0;
      err_expect <= '0;
      err_actual <= '0;
    end else begin
      case (state)
        S_INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == AW'(WORD_NUM - 1))
            state <= S_IDLE;
        end
        S_IDLE: begin
          if (start)
            state <= S_RUN;
        end
        S_RUN: begin
          if (issue) begin
            wr_ptr  <= wr_ptr + 1'b1;
            vec_idx <= vec_idx + 1'b1;
          end
          if (pop) begin
            rd_ptr     <= rd_ptr + 1'b1;
            commit_cnt <= commit_cnt + 1'b1;
          end
          if (issue && !pop)
            count <= count + 1'b1;
          else if (!issue && pop)
            count <= count - 1'b1;
          if (commit_run || fifo_empty)
            wdog <= '0;
          else
            wdog <= wdog + 1'b1;
          // Error branches come first so a failing final commit never passes.
          if (commit_run && fifo_empty) begin
            state    <= S_FAIL;
            done     <= 1'b1;
            err_code <= 2'd3;
            err_idx  <= commit_cnt;
          end else if (pop && load_bad) begin
            state      <= S_FAIL;
            done       <= 1'b1;
            err_code   <= 2'd1;
            err_idx    <= head.idx;
            err_expect <= expected;
            err_actual <= dut_rdata;
          end else if (!commit_run && !fifo_empty && wdog == 32'(TIMEOUT - 1)) begin
            state    <= S_FAIL;
            done     <= 1'b1;
            err_code <= 2'd2;
            err_idx  <= head.idx;
          end else if (pop && commit_cnt == 32'(TEST_NUM - 1)) begin
            state <= S_PASS;
            done  <= 1'b1;
            pass  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
